// File: rtl/ifq_pkg.sv
// Shared types and default sizing for the multi-line instruction fetch queue.
// Width localparams are derived from the default geometry with $clog2.
package ifq_pkg;

    localparam int IFQ_XLEN       = 32;
    localparam int IFQ_LINE_WORDS = 4;
    localparam int IFQ_DEPTH      = 16;
    localparam int IFQ_OFF_W      = $clog2(IFQ_LINE_WORDS);
    localparam int IFQ_PTR_W      = $clog2(IFQ_DEPTH);
    localparam int IFQ_CNT_W      = IFQ_PTR_W + 1;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ring_mw.sv
// Circular buffer with a 0..LINE_WORDS-entry push port and one pop port.
// Flush clears the pointers and count in one cycle; stored entries are left as is.
module ifq_ring_mw
    import ifq_pkg::*;
#(
    parameter int DEPTH      = IFQ_DEPTH,
    parameter int LINE_WORDS = IFQ_LINE_WORDS,
    parameter type entry_t   = ifq_entry_t
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [$clog2(LINE_WORDS):0]   push_n,
    input  entry_t                        push_data [LINE_WORDS],
    input  logic                          pop,
    output entry_t                        head,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(LINE_WORDS) + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rp];

    // Write lane j lands at wp+j; the pointer wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int j = 0; j < LINE_WORDS; j++) begin
                if (NW'(j) < push_n) begin
                    mem[wp + PW'(j)] <= push_data[j];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(push_n);
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            count <= count + CW'(push_n) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ifq_multi_line.sv
// Instruction fetch queue: requests whole cache lines, queues each word with
// its own PC, and serves Dispatch one instruction per cycle with bypass.
module ifq_multi_line
    import ifq_pkg::*;
#(
    parameter int              XLEN       = IFQ_XLEN,
    parameter int              LINE_WORDS = IFQ_LINE_WORDS,
    parameter int              DEPTH      = IFQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            pc_in,
    output logic                       cache_rd_en,
    output logic                       cache_abort,
    input  logic [LINE_WORDS*XLEN-1:0] dout,
    input  logic                       dout_valid,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            inst,
    output logic                       empty,
    input  logic                       inst_rd_en,
    input  logic [XLEN-1:0]            jmp_branch_address,
    input  logic                       jmp_branch_valid
);

    localparam int OW = $clog2(LINE_WORDS);
    localparam int NW = OW + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LB = OW + 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   off;
    logic [NW-1:0]   k;
    logic [NW-1:0]   push_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic            line_in;
    logic            bypass;
    logic            skip;
    logic            pop;
    entry_t          head;
    entry_t          words [LINE_WORDS];
    entry_t          push_data [LINE_WORDS];

    assign off   = fetch_pc[2 +: OW];
    assign pc_in = fetch_pc & ~XLEN'((1 << LB) - 1);
    assign k     = NW'(LINE_WORDS) - NW'(off);
    assign free  = CW'(DEPTH) - count;

    // A redirect or reset masks every other action in the same cycle.
    assign cache_rd_en = !rst && !jmp_branch_valid
                       && (state == IDLE) && (free >= CW'(k));
    assign cache_abort = !rst && jmp_branch_valid && (state == WAIT);

    assign line_in = !rst && !jmp_branch_valid
                   && (state == WAIT) && dout_valid;
    assign bypass  = line_in && (count == '0);
    assign skip    = bypass && inst_rd_en;
    assign push_n  = line_in ? (k - NW'(skip)) : '0;
    assign pop     = !rst && !jmp_branch_valid
                   && inst_rd_en && (count != '0);

    // Slice the returned line into words, each tagged with its byte PC.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            words[i].pc   = pc_in + XLEN'(4 * i);
            words[i].inst = dout[i*XLEN +: XLEN];
        end
    end

    // Compact words off.. (minus a bypassed head) onto the push lanes.
    always_comb begin
        logic [NW:0] idx;
        for (int j = 0; j < LINE_WORDS; j++) begin
            push_data[j] = '0;
            idx = (NW+1)'(off) + (NW+1)'(j) + (NW+1)'(skip);
            if (idx < (NW+1)'(LINE_WORDS)) begin
                push_data[j] = words[idx[OW-1:0]];
            end
        end
    end

    // Head selection: bypass word, queue head, or zeros when empty.
    always_comb begin
        empty  = 1'b1;
        inst   = '0;
        pc_out = '0;
        if (bypass) begin
            empty  = 1'b0;
            inst   = words[off].inst;
            pc_out = words[off].pc;
        end else if (!rst && !jmp_branch_valid && (count != '0)) begin
            empty  = 1'b0;
            inst   = head.inst;
            pc_out = head.pc;
        end
    end

    // Fetch FSM: one outstanding line request, redirect has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else if (jmp_branch_valid) begin
            state    <= IDLE;
            fetch_pc <= jmp_branch_address;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_rd_en) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dout_valid) begin
                        fetch_pc <= pc_in + XLEN'(4 * LINE_WORDS);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifq_ring_mw #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .entry_t    (entry_t)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .flush     (jmp_branch_valid),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
